// File: rtl/cpu16_exec_ctrl.sv
// cpu16_exec_ctrl: multi-cycle fetch/decode/execute/memory/writeback sequencer
// for the 16-bit CPU. Owns the 8x16 register file, drives the external ALU
// from registered operands and captures its result, and runs load/store
// through a request/acknowledge data-memory port.
module cpu16_exec_ctrl #(
  parameter int PC_W = 8,
  parameter int NREG = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_run,
  output logic [PC_W-1:0] o_imem_addr,
  output logic            o_imem_req,
  input  logic            i_imem_ack,
  input  logic [15:0]     i_imem_data,
  output logic [4:0]      o_alu_op,
  output logic [15:0]     o_alu_r1,
  output logic [15:0]     o_alu_r2,
  input  logic [15:0]     i_alu_a,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [15:0]     o_dmem_addr,
  output logic [15:0]     o_dmem_wdata,
  input  logic [15:0]     i_dmem_rdata,
  input  logic            i_dmem_ack,
  output logic            o_busy
);

  // Shared opcode header values (also understood by the ALU).
  localparam logic [4:0] OP_ADD   = 5'h01;
  localparam logic [4:0] OP_SUB   = 5'h02;
  localparam logic [4:0] OP_ADDI  = 5'h03;
  localparam logic [4:0] OP_SUBI  = 5'h04;
  localparam logic [4:0] OP_AND   = 5'h05;
  localparam logic [4:0] OP_OR    = 5'h06;
  localparam logic [4:0] OP_XOR   = 5'h07;
  localparam logic [4:0] OP_NOT   = 5'h08;
  localparam logic [4:0] OP_CMP1  = 5'h09;
  localparam logic [4:0] OP_MOVE  = 5'h0A;
  localparam logic [4:0] OP_LOAD  = 5'h0B;
  localparam logic [4:0] OP_STORE = 5'h0C;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic [15:0]     r_rf [NREG];
  logic [4:0]      r_alu_op;
  logic [15:0]     r_alu_r1;
  logic [15:0]     r_alu_r2;
  logic [15:0]     r_res;
  logic [15:0]     r_dmem_addr;
  logic [15:0]     r_dmem_wdata;

  // Instruction fields of the instruction currently held in IR.
  logic [4:0]      w_op;
  logic [2:0]      w_rd;
  logic [2:0]      w_rs;
  logic [2:0]      w_rt;
  logic [15:0]     w_imm;
  logic            w_is_imm;
  logic            w_is_load;
  logic            w_is_store;
  logic            w_is_mem;
  logic            w_defined;
  logic            w_writes_back;

  logic            w_imem_req;
  logic            w_dmem_req;
  logic            w_dmem_we;
  logic            w_busy;

  assign w_op          = r_ir[15:11];
  assign w_rd          = r_ir[10:8];
  assign w_rs          = r_ir[7:5];
  assign w_rt          = r_ir[4:2];
  assign w_imm         = {11'd0, r_ir[4:0]};
  assign w_is_imm      = (w_op == OP_ADDI) || (w_op == OP_SUBI);
  assign w_is_load     = (w_op == OP_LOAD);
  assign w_is_store    = (w_op == OP_STORE);
  assign w_is_mem      = w_is_load || w_is_store;
  // Opcodes outside the header range behave as NOPs.
  assign w_defined     = (w_op >= OP_ADD) && (w_op <= OP_STORE);
  assign w_writes_back = w_defined && !w_is_store;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; FETCH and MEM wait for their acknowledge.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (i_run) w_state_next = S_FETCH;
      S_FETCH:  if (i_imem_ack) w_state_next = S_DECODE;
      S_DECODE: w_state_next = S_EXEC;
      S_EXEC:   w_state_next = w_is_mem ? S_MEM : S_WB;
      S_MEM:    if (i_dmem_ack) w_state_next = S_WB;
      S_WB:     w_state_next = i_run ? S_FETCH : S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // State-decoded handshake outputs; requests exist only in their own state.
  always_comb begin
    w_imem_req = (r_state == S_FETCH);
    w_dmem_req = (r_state == S_MEM);
    w_dmem_we  = (r_state == S_MEM) && w_is_store;
    w_busy     = (r_state != S_IDLE);
  end

  // Fetch: capture the instruction and advance pc (wraps naturally).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= '0;
      r_ir <= '0;
    end else if (r_state == S_FETCH && i_imem_ack) begin
      r_ir <= i_imem_data;
      r_pc <= r_pc + 1'b1;
    end
  end

  // Decode: register the ALU opcode and operands so they are stable from EXEC on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu_op <= '0;
      r_alu_r1 <= '0;
      r_alu_r2 <= '0;
    end else if (r_state == S_DECODE) begin
      r_alu_op <= w_op;
      r_alu_r1 <= r_rf[w_rs];
      r_alu_r2 <= w_is_imm ? w_imm : r_rf[w_rt];
    end
  end

  // Execute/memory: latch the ALU result, set up the data access, and for
  // loads replace the result with the returned data on acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res        <= '0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
    end else if (r_state == S_EXEC) begin
      r_res <= i_alu_a;
      if (w_is_load) begin
        r_dmem_addr <= i_alu_a;
      end else if (w_is_store) begin
        r_dmem_addr  <= r_alu_r1;
        r_dmem_wdata <= i_alu_a;
      end
    end else if (r_state == S_MEM && i_dmem_ack && w_is_load) begin
      r_res <= i_dmem_rdata;
    end
  end

  // Register file writeback at the end of WB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else if (r_state == S_WB && w_writes_back) begin
      for (int i = 0; i < NREG; i++) begin
        if (w_rd == 3'(i)) begin
          r_rf[i] <= r_res;
        end
      end
    end
  end

  assign o_imem_addr  = r_pc;
  assign o_imem_req   = w_imem_req;
  assign o_alu_op     = r_alu_op;
  assign o_alu_r1     = r_alu_r1;
  assign o_alu_r2     = r_alu_r2;
  assign o_dmem_req   = w_dmem_req;
  assign o_dmem_we    = w_dmem_we;
  assign o_dmem_addr  = r_dmem_addr;
  assign o_dmem_wdata = r_dmem_wdata;
  assign o_busy       = w_busy;

endmodule

// File: doc/cpu16_exec_ctrl.md
Name: cpu16_exec_ctrl

Overview:
Multi-cycle instruction sequencer for the 16-bit CPU. It sits directly upstream of the ALU and also consumes its result.
- Fetches 16-bit instructions and decodes them.
- Reads an internal 8x16 register file and drives the ALU opcode and operands.
- Latches the ALU result, performs load/store through a data-memory handshake and writes back to the register file.

Parameters:
PC_W, 8, program counter / instruction address width
NREG, 8, register-file depth (register index fixed at 3 bits)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous reset, active low
run  in  1  1 = sequencer may leave IDLE and fetch
imem_addr  out  PC_W  instruction address (= pc)
imem_req  out  1  instruction fetch request
imem_ack  in  1  instruction valid on imem_data this cycle
imem_data  in  16  instruction word
alu_op  out  5  ALU opcode (shared opcode header values)
alu_r1  out  16  ALU operand 1
alu_r2  out  16  ALU operand 2
alu_a  in  16  ALU result (combinational from alu_op/r1/r2)
dmem_req  out  1  data memory request
dmem_we  out  1  1 = write (store), 0 = read (load)
dmem_addr  out  16  data address
dmem_wdata  out  16  store data
dmem_rdata  in  16  load data, valid with dmem_ack
dmem_ack  in  1  data access complete
busy  out  1  1 whenever state != IDLE

Behaviour:
Instruction format:
- op = [15:11], rd = [10:8], rs = [7:5].
- rt = [4:2] for R-type.
- imm5 = [4:0] for addi/subi, zero-extended to 16 bits.

Operand mapping:
- alu_r1 = R[rs].
- alu_r2 = imm for addi/subi; otherwise R[rt].
- move: R[rd] <= R[rt].
- load: R[rd] <= mem[R[rs]], with dmem_addr = alu_a.
- store: mem[R[rs]] <= R[rt], with dmem_addr = R[rs] and dmem_wdata = alu_a.

Writeback set:
- Writes back: every defined opcode except store.
- Opcodes not in the shared header act as NOP: no register write, no memory access.

States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- IDLE: no requests. If run=1, go to FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack: IR <= imem_data, pc <= pc+1 (wraps modulo 2^PC_W), go to DECODE.
  - Otherwise hold.
- DECODE: latch opA, opB and alu_op into registers; go to EXEC. ALU outputs are registered, stable from EXEC onward.
- EXEC: res <= alu_a. If load/store, go to MEM; otherwise go to WB.
- MEM: dmem_req=1, dmem_we = (op==store). dmem_addr and dmem_wdata are held stable while waiting.
  - On dmem_ack: load captures res <= dmem_rdata; go to WB.
- WB: if the op writes back, R[rd] <= res. Then go to FETCH if run=1, else IDLE.

Handshake rules:
- imem_req and dmem_req are asserted only in their state and stay high until ack.
- An ack arriving outside FETCH/MEM is ignored.

Latency (single-cycle acks):
- ALU op: 4 cycles from FETCH entry to WB complete.
- load/store: 5 cycles.

Simultaneous events and hazards:
- run deasserted mid-instruction: the instruction completes; the sequencer stops after WB.
- WB writes R[rd] at the end of the WB cycle. The next instruction reads registers in DECODE, at least 2 cycles later, so there is no hazard.

Reset (rst_n=0 at a clock edge):
- state=IDLE, pc=0, IR=0, all registers=0.
- alu_op=0, alu_r1=0, alu_r2=0, res=0.
- imem_req=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, busy=0.
- Reset mid-operation aborts immediately; a pending memory request is dropped the same edge.

Test Plan:
- Reset, then run=1, imem ack every cycle, program "addi r1,r0,5; addi r2,r0,3; add r3,r1,r2" -> after 12 cycles R3=8, imem_addr=3, each instruction spans 4 cycles.
- R1=0x00F0, R2=0x0F0F: sub r4,r1,r2 -> R4=0xF1E1; NOT r5,r1 -> R5=0xFF0F; cmp1 r6,r1,r2 -> R6=0x00F0.
- R1=0x0010, R2=0xBEEF: store [r1]<=r2 then load r7,[r1] -> dmem_we=1 with addr=0x0010, wdata=0xBEEF; then read, R7=0xBEEF. dmem_ack delayed 3 cycles: req and address held stable, no write to R7 until ack.
- pc=0xFF fetch -> pc wraps to 0x00; undefined opcode at that address -> no register changes, next fetch proceeds.
- rst_n=0 during MEM with dmem_req=1 -> next cycle dmem_req=0, state IDLE, pc=0, all registers 0; late dmem_ack ignored.
- run dropped during EXEC of add -> WB completes (R[rd] updated), then IDLE, busy=0, imem_req stays 0 until run=1.
